// File: rtl/cache_pkg.sv
// Types and constants shared by the L1/L2 cache controllers.
package cache_pkg;
  localparam int LINE_BITS   = 512;
  localparam int ADDR_BITS   = 32;
  localparam int OFFSET_BITS = 6;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  // Request as latched at grant time and replayed onto the L2 port
  typedef struct packed {
    logic [ADDR_BITS-1:0] add;
    logic                 we;
    logic [LINE_BITS-1:0] wdata;
  } l2_req_t;

  function automatic logic [ADDR_BITS-1:0] line_addr(input logic [ADDR_BITS-1:0] a);
    return {a[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; on a tie the side that was not granted last wins.
module rr_arb2
  import cache_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_e last,
  output logic   gnt_vld,
  output owner_e gnt
);
  always_comb begin
    gnt_vld = i_req | d_req;
    gnt     = OWN_I;
    if (i_req && d_req) gnt = (last == OWN_I) ? OWN_D : OWN_I;
    else if (d_req)     gnt = OWN_D;
  end
endmodule

// File: rtl/l2_arbiter.sv
// Serializes I-cache fills and D-cache fills/write-backs onto one L2 port,
// modelling a fixed L2 latency and returning each line with a done pulse.
module l2_arbiter
  import cache_pkg::*;
#(
  parameter int L2_LATENCY = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req,
  input  logic [ADDR_BITS-1:0] i_add,
  output logic                 i_done,
  output logic [LINE_BITS-1:0] i_data,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_BITS-1:0] d_add,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic                 d_done,
  output logic [LINE_BITS-1:0] d_data,
  output logic [ADDR_BITS-1:0] l2_add,
  output logic                 l2_we,
  output logic [LINE_BITS-1:0] l2_wdata,
  input  logic [LINE_BITS-1:0] l2_rdata,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] i_grants,
  output logic [CNT_WIDTH-1:0] d_grants
);
  localparam logic [7:0] LAT_M1 = 8'(L2_LATENCY - 1);

  state_e  state, state_nxt;
  owner_e  own, last, gnt;
  logic    gnt_vld;
  logic [7:0] cnt;
  l2_req_t req_q;

  rr_arb2 u_arb (
    .i_req   (i_req),
    .d_req   (d_req),
    .last    (last),
    .gnt_vld (gnt_vld),
    .gnt     (gnt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = ACCESS;
      ACCESS:  if (cnt == 8'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      own      <= OWN_I;
      last     <= OWN_D;
      cnt      <= '0;
      req_q    <= '0;
      i_data   <= '0;
      d_data   <= '0;
      i_grants <= '0;
      d_grants <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (gnt_vld) begin
          own  <= gnt;
          last <= gnt;
          cnt  <= LAT_M1;
          if (gnt == OWN_D) begin
            req_q <= '{add: line_addr(d_add), we: d_we, wdata: d_wdata};
            if (d_grants != '1) d_grants <= d_grants + 1'b1;
          end else begin
            // wdata is left as-is; l2_we stays low for I fills
            req_q.add <= line_addr(i_add);
            req_q.we  <= 1'b0;
            if (i_grants != '1) i_grants <= i_grants + 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == 8'd0) begin
            if (!req_q.we) begin
              if (own == OWN_I) i_data <= l2_rdata;
              else              d_data <= l2_rdata;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign l2_add   = req_q.add;
  assign l2_we    = (state == ACCESS) && req_q.we;
  assign l2_wdata = req_q.wdata;
  assign busy     = (state != IDLE);
  assign i_done   = (state == DONE) && (own == OWN_I);
  assign d_done   = (state == DONE) && (own == OWN_D);
endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench: main arbiter (latency 4) plus a 2-bit-counter, latency-1 copy.
module tb_l2_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic logic [511:0] model(input logic [31:0] a);
    return {16{a ^ 32'hDEAD_BEEF}};
  endfunction

  // main DUT
  logic         i_req, d_req, d_we, i_done, d_done, l2_we, busy;
  logic [31:0]  i_add, d_add, l2_add, i_grants, d_grants;
  logic [511:0] d_wdata, i_data, d_data, l2_wdata, l2_rdata;
  assign l2_rdata = model(l2_add);

  l2_arbiter #(.L2_LATENCY(4), .CNT_WIDTH(32)) u0 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_add(i_add), .i_done(i_done), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_add(d_add), .d_wdata(d_wdata),
    .d_done(d_done), .d_data(d_data),
    .l2_add(l2_add), .l2_we(l2_we), .l2_wdata(l2_wdata), .l2_rdata(l2_rdata),
    .busy(busy), .i_grants(i_grants), .d_grants(d_grants)
  );

  // small-counter DUT
  logic         s_i_req, s_d_req, s_d_we, s_i_done, s_d_done, s_l2_we, s_busy;
  logic [31:0]  s_i_add, s_d_add, s_l2_add;
  logic [1:0]   s_i_grants, s_d_grants;
  logic [511:0] s_d_wdata, s_i_data, s_d_data, s_l2_wdata, s_l2_rdata;
  assign s_l2_rdata = model(s_l2_add);

  l2_arbiter #(.L2_LATENCY(1), .CNT_WIDTH(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(s_i_req), .i_add(s_i_add), .i_done(s_i_done), .i_data(s_i_data),
    .d_req(s_d_req), .d_we(s_d_we), .d_add(s_d_add), .d_wdata(s_d_wdata),
    .d_done(s_d_done), .d_data(s_d_data),
    .l2_add(s_l2_add), .l2_we(s_l2_we), .l2_wdata(s_l2_wdata), .l2_rdata(s_l2_rdata),
    .busy(s_busy), .i_grants(s_i_grants), .d_grants(s_d_grants)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int side);
    case (side)
      0:       return i_done;
      1:       return d_done;
      default: return s_d_done;
    endcase
  endfunction

  // Waits on negedges until the chosen done is seen; n = negedges waited.
  task automatic wait_done(input int side, input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_of(side) && n < 20);
    chk({tag, "_done_seen"}, done_of(side), 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int n, who, we_cnt, bad;
  logic d_early;

  initial begin
    rst_n = 1'b0;
    i_req = 0; i_add = '0; d_req = 0; d_we = 0; d_add = '0; d_wdata = '0;
    s_i_req = 0; s_i_add = '0; s_d_req = 0; s_d_we = 0; s_d_add = '0; s_d_wdata = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_l2_add", l2_add, 32'h0);
    chk("rst_l2_we", l2_we, 1'b0);
    chk("rst_l2_wdata", l2_wdata, '0);
    chk("rst_i_data", i_data, '0);
    chk("rst_d_data", d_data, '0);
    chk("rst_grants", {i_grants, d_grants}, 64'h0);
    chk("rst_done", {i_done, d_done}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    // single read, latency 4
    i_req = 1'b1; i_add = 32'h0000_1234;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("rd_l2_add", l2_add, 32'h0000_1200);
      chk("rd_no_done", i_done, 1'b0);
      chk("rd_busy", busy, 1'b1);
    end
    @(negedge clk);
    chk("rd_i_done", i_done, 1'b1);
    chk("rd_i_data", i_data, model(32'h0000_1200));
    chk("rd_i_grants", i_grants, 32'd1);
    i_req = 1'b0;
    @(negedge clk);
    chk("rd_done_fall", i_done, 1'b0);
    chk("rd_idle", busy, 1'b0);

    // simultaneous requests: I wins first tie after reset, then alternate
    do_reset();
    i_req = 1'b1; i_add = 32'h0000_0100; d_req = 1'b1; d_we = 1'b0; d_add = 32'h0000_0200;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!i_done && !d_done && n < 20);
      chk("tie_any_done", i_done | d_done, 1'b1);
      who = d_done ? 1 : 0;
      chk("tie_order", 1'(who), 1'(g % 2));
      if (who == 0) begin
        chk("tie_i_data", i_data, model(32'h0000_0100));
        i_req = 1'b0;
      end else begin
        chk("tie_d_data", d_data, model(32'h0000_0200));
        d_req = 1'b0;
      end
      if (g == 3) begin
        i_req = 1'b0; d_req = 1'b0;
      end else begin
        @(negedge clk);
        if (who == 0) i_req = 1'b1; else d_req = 1'b1;
      end
    end
    repeat (2) @(negedge clk);
    chk("tie_i_grants", i_grants, 32'd2);
    chk("tie_d_grants", d_grants, 32'd2);
    chk("tie_idle", busy, 1'b0);

    // write-back
    d_req = 1'b1; d_we = 1'b1; d_add = 32'h8000_0040; d_wdata = {64{8'hA5}};
    n = 0; we_cnt = 0; bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (l2_we) begin
        we_cnt++;
        if (l2_wdata !== {64{8'hA5}} || l2_add !== 32'h8000_0040) bad++;
      end
    end while (!d_done && n < 20);
    chk("wr_done_seen", d_done, 1'b1);
    chk("wr_latency", 32'(n), 32'd5);
    chk("wr_we_cycles", 32'(we_cnt), 32'd4);
    chk("wr_port_bad", 32'(bad), 32'd0);
    chk("wr_d_data_kept", d_data, model(32'h0000_0200));
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("wr_we_low", l2_we, 1'b0);
    chk("wr_add_hold", l2_add, 32'h8000_0040);
    chk("wr_d_grants", d_grants, 32'd3);

    // late arrival of D during an I access
    i_req = 1'b1; i_add = 32'h0000_3000;
    @(negedge clk);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_add = 32'h0000_4000;
    n = 0; d_early = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (d_done) d_early = 1'b1;
    end while (!i_done && n < 20);
    chk("late_i_done", i_done, 1'b1);
    chk("late_i_lat", 32'(n), 32'd3);
    chk("late_no_d_early", d_early, 1'b0);
    chk("late_i_data", i_data, model(32'h0000_3000));
    i_req = 1'b0;
    wait_done(1, "late_d", n);
    chk("late_d_lat", 32'(n), 32'd6);
    chk("late_d_data", d_data, model(32'h0000_4000));
    chk("late_i_kept", i_data, model(32'h0000_3000));
    d_req = 1'b0;
    @(negedge clk);

    // reset in the third ACCESS cycle
    i_req = 1'b1; i_add = 32'h0000_5000;
    repeat (3) @(negedge clk);
    chk("mid_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_no_done", {i_done, d_done}, 2'b00);
    chk("mid_busy", busy, 1'b0);
    chk("mid_l2_add", l2_add, 32'h0);
    chk("mid_data", {i_data, d_data}, '0);
    chk("mid_grants", {i_grants, d_grants}, 64'h0);
    rst_n = 1'b1;
    wait_done(0, "mid_reissue", n);
    chk("mid_reissue_lat", 32'(n), 32'd5);
    chk("mid_reissue_data", i_data, model(32'h0000_5000));
    chk("mid_i_grants", i_grants, 32'd1);
    i_req = 1'b0;
    @(negedge clk);

    // 2-bit counter saturation, latency 1
    for (int k = 0; k < 5; k++) begin
      s_d_req = 1'b1; s_d_add = 32'h0000_1000 + 32'(k * 64) + 32'd5;
      wait_done(2, "sat", n);
      chk("sat_lat", 32'(n), 32'd2);
      chk("sat_data", s_d_data, model(32'h0000_1000 + 32'(k * 64)));
      s_d_req = 1'b0;
      @(negedge clk);
      if (k == 1) chk("sat_mid", s_d_grants, 2'd2);
    end
    chk("sat_d_grants", s_d_grants, 2'd3);
    chk("sat_i_grants", s_i_grants, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
